miner_slave_regfile: RTL

Parametrised memory-mapped register file between the host slave bus and the SHA-256 miner core. It collects message and target words written by the host into shadow banks, launches the core on a control write, and tracks core progress in a state machine. It captures the resulting hash, exposes status and hash for readback, and optionally raises an interrupt. Message length, target width and the address map scale with parameters.

---
 rtl/miner_slave_regfile_pkg.sv | 40 ++++
 rtl/miner_slave_regfile_if.sv | 39 +++
 rtl/miner_slave_regfile_bank.sv | 38 +++
 rtl/miner_slave_regfile.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/miner_slave_regfile_pkg.sv
// ============================================================================
// Module   : miner_pkg
// Brief    : Shared constants, state encoding and helpers for the miner slave
//            register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package miner_pkg;

    // Fixed register addresses
    localparam int c_ctrl_addr   = 0;
    localparam int c_status_addr = 1;
    localparam int c_rsvd_addr   = 2;
    localparam int c_msg_base    = 3;

    // CTRL bit positions
    localparam int c_ctrl_load_tgt = 0;
    localparam int c_ctrl_start    = 1;
    localparam int c_ctrl_abort    = 2;

    // STATUS bit positions
    localparam int c_stat_busy    = 0;
    localparam int c_stat_done    = 1;
    localparam int c_stat_valid   = 2;
    localparam int c_stat_overrun = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } miner_state_t;

    function automatic int words_for_bits(input int bits);
        return (bits + 31) / 32;
    endfunction

endpackage

`default_nettype wire

// File: rtl/miner_slave_regfile_if.sv
// ============================================================================
// Module   : miner_slave_regfile_if
// Brief    : Host slave bus carrying word address, write data and read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface miner_slave_regfile_if #(
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] slaveAddr;
    logic [31:0]       slaveWriteData;
    logic              slaveWrite;
    logic              slaveRead;
    logic              slaveChipSelect;
    logic [31:0]       slaveReadData;

    modport master (
        output slaveAddr,
        output slaveWriteData,
        output slaveWrite,
        output slaveRead,
        output slaveChipSelect,
        input  slaveReadData
    );

    modport slave (
        input  slaveAddr,
        input  slaveWriteData,
        input  slaveWrite,
        input  slaveRead,
        input  slaveChipSelect,
        output slaveReadData
    );

endinterface

`default_nettype wire

// File: rtl/miner_slave_regfile_bank.sv
// ============================================================================
// Module   : miner_word_bank
// Brief    : N x 32-bit write-addressable shadow bank at address BASE; word 0
//            is the least significant word of the flattened output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module miner_word_bank #(
    parameter int N      = 8,
    parameter int BASE   = 0,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              n_rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output      logic [32*N-1:0]   o_data
);

    logic [31:0] r_word [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_word
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_word[gi] <= '0;
            end else if (i_we && (i_addr == ADDR_W'(BASE + gi))) begin
                r_word[gi] <= i_wdata;
            end
        end

        assign o_data[gi*32 +: 32] = r_word[gi];
    end

endmodule

`default_nettype wire

// File: rtl/miner_slave_regfile.sv
// ============================================================================
// Module   : miner_slave_regfile
// Brief    : Host register file for the SHA-256 miner core: shadow banks,
//            launch control, progress FSM, hash capture and status readback.
//            Optional interrupt output enabled by defining MINER_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module miner_slave_regfile
    import miner_pkg::*;
#(
    parameter int MSG_BITS   = 408,
    parameter int TGT_WORDS  = 8,
    parameter int HASH_WORDS = 8,
    parameter int ADDR_W     = 5
) (
    input  wire logic                    clk,
    input  wire logic                    n_rst,
    miner_slave_regfile_if.slave         bus,
    output      logic                    newTarget,
    output      logic                    newMsg,
    output      logic [32*TGT_WORDS-1:0] targetOut,
    output      logic [MSG_BITS-1:0]     msgOut,
    input  wire logic                    coreDone,
    input  wire logic                    coreValid,
    input  wire logic [32*HASH_WORDS-1:0] coreHash
`ifdef MINER_IRQ_EN
    ,
    output      logic                    irq
`endif
);

    localparam int MSG_WORDS = words_for_bits(MSG_BITS);
    localparam int TGT_BASE  = c_msg_base + MSG_WORDS;
    localparam int HASH_BASE = TGT_BASE + TGT_WORDS;

    if (c_msg_base + MSG_WORDS + TGT_WORDS + HASH_WORDS > 2**ADDR_W) begin : g_cfg_check
        $error("miner_slave_regfile: address map does not fit in ADDR_W");
    end

    logic                     w_wr;
    logic                     w_rd;
    logic                     w_ctrl_wr;
    logic                     w_stat_rd;
    logic                     w_load_tgt;
    logic                     w_start;
    logic                     w_abort;
    logic                     w_launch;
    logic                     w_capture;
    logic                     w_ovr_set;
    logic [31:0]              w_rd_word;
    logic [32*MSG_WORDS-1:0]  w_msg_bank;
    logic [32*TGT_WORDS-1:0]  w_tgt_bank;

    miner_state_t             r_state;
    miner_state_t             w_state_nxt;
    logic                     r_done;
    logic                     r_valid;
    logic                     r_overrun;
    logic                     r_new_msg;
    logic                     r_new_tgt;
    logic [MSG_BITS-1:0]      r_msg_out;
    logic [32*TGT_WORDS-1:0]  r_tgt_out;
    logic [32*HASH_WORDS-1:0] r_hash;
    logic [31:0]              r_rdata;

    assign w_wr       = bus.slaveChipSelect && bus.slaveWrite;
    assign w_rd       = bus.slaveChipSelect && bus.slaveRead;
    assign w_ctrl_wr  = w_wr && (bus.slaveAddr == ADDR_W'(c_ctrl_addr));
    assign w_stat_rd  = w_rd && (bus.slaveAddr == ADDR_W'(c_status_addr));
    assign w_load_tgt = w_ctrl_wr && bus.slaveWriteData[c_ctrl_load_tgt];
    assign w_start    = w_ctrl_wr && bus.slaveWriteData[c_ctrl_start];
    assign w_abort    = w_ctrl_wr && bus.slaveWriteData[c_ctrl_abort];

    miner_word_bank #(
        .N      (MSG_WORDS),
        .BASE   (c_msg_base),
        .ADDR_W (ADDR_W)
    ) u_msg_bank (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_we    (w_wr),
        .i_addr  (bus.slaveAddr),
        .i_wdata (bus.slaveWriteData),
        .o_data  (w_msg_bank)
    );

    miner_word_bank #(
        .N      (TGT_WORDS),
        .BASE   (TGT_BASE),
        .ADDR_W (ADDR_W)
    ) u_tgt_bank (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_we    (w_wr),
        .i_addr  (bus.slaveAddr),
        .i_wdata (bus.slaveWriteData),
        .o_data  (w_tgt_bank)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state; ABORT overrides both START and coreDone
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_launch)  w_state_nxt = BUSY;
            BUSY:       if (w_capture) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    // FSM: decoded actions
    always_comb begin
        w_launch  = w_start && !w_abort && (r_state != BUSY);
        w_ovr_set = w_start && !w_abort && (r_state == BUSY);
        w_capture = coreDone && !w_abort && (r_state == BUSY);
    end

    // Status flags: a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_hash    <= '0;
        end else begin
            if (w_capture) begin
                r_done  <= 1'b1;
                r_valid <= coreValid;
                r_hash  <= coreHash;
            end else if (w_launch) begin
                r_done  <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_stat_rd) begin
                r_done  <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_new_msg <= 1'b0;
            r_new_tgt <= 1'b0;
            r_msg_out <= '0;
            r_tgt_out <= '0;
        end else begin
            r_new_msg <= w_launch;
            r_new_tgt <= w_load_tgt;
            if (w_launch) begin
                r_msg_out <= w_msg_bank[32*MSG_WORDS-1 -: MSG_BITS];
            end
            if (w_load_tgt) begin
                r_tgt_out <= w_tgt_bank;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (bus.slaveAddr == ADDR_W'(c_status_addr)) begin
            w_rd_word[c_stat_busy]    = (r_state == BUSY);
            w_rd_word[c_stat_done]    = r_done;
            w_rd_word[c_stat_valid]   = r_valid;
            w_rd_word[c_stat_overrun] = r_overrun;
        end
        for (int i = 0; i < MSG_WORDS; i++) begin
            if (bus.slaveAddr == ADDR_W'(c_msg_base + i)) w_rd_word = w_msg_bank[i*32 +: 32];
        end
        for (int i = 0; i < TGT_WORDS; i++) begin
            if (bus.slaveAddr == ADDR_W'(TGT_BASE + i)) w_rd_word = w_tgt_bank[i*32 +: 32];
        end
        for (int i = 0; i < HASH_WORDS; i++) begin
            if (bus.slaveAddr == ADDR_W'(HASH_BASE + i)) w_rd_word = r_hash[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_word;
        end
    end

`ifdef MINER_IRQ_EN
    logic r_irq;

    // Follows done by one cycle in both directions
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done;
        end
    end

    assign irq = r_irq;
`endif

    assign bus.slaveReadData = r_rdata;
    assign newMsg            = r_new_msg;
    assign newTarget         = r_new_tgt;
    assign msgOut            = r_msg_out;
    assign targetOut         = r_tgt_out;

endmodule

`default_nettype wire
